ifetch_prefetch: RTL
====================

Name: ifetch_prefetch

Overview:
- Instruction prefetch queue between the instruction-side Wishbone master port of the arbiter and the fetch stage.
- Issues sequential pipelined Wishbone reads ahead of the fetch stage and buffers the returned words with their PCs in a small FIFO.
- Delivers one word per cycle to the fetch stage.
- Flushes and redirects when the pipeline asserts a PC change from the memory stage.

Parameters:
- DEPTH, 4, FIFO entries; also the cap on (buffered + outstanding) requests; power of 2, from 2 to 16.
- RESET_PC, 32'h0, first fetch address after reset; word-aligned.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- pc_set_i  in  1  redirect request (branch or exception from the memory stage)
- pc_i  in  32  redirect target
- pop_i  in  1  fetch stage consumes the head entry
- valid_o  out  1  head entry valid
- word_o  out  32  head instruction word
- word_pc_o  out  32  byte address of the head word
- bus_cyc_o  out  1  Wishbone cycle
- bus_stb_o  out  1  Wishbone strobe
- bus_adr_o  out  32  Wishbone byte address; bits [1:0] always 0
- bus_stall_i  in  1  Wishbone pipelined stall
- bus_ack_i  in  1  Wishbone acknowledge
- bus_dat_i  in  32  Wishbone read data

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=RUN, fetch address = RESET_PC, FIFO empty, outstanding=0, drain=0.
  - Outputs: valid_o=0, bus_cyc_o=0, bus_stb_o=0, bus_adr_o=RESET_PC, word_o=0, word_pc_o=0.
- States:
  - RUN: normal prefetch.
  - DRAIN: discarding acks for requests issued before a redirect.
- Issue (RUN only):
  - bus_stb_o=1 when (fifo_count + outstanding) < DEPTH.
  - A request is accepted when stb & !bus_stall_i.
  - On acceptance: outstanding+1, fetch address +4.
  - Address wraps from 32'hFFFFFFFC to 0.
- bus_cyc_o=1 whenever bus_stb_o=1 or outstanding>0.
- No write cycles are generated; the arbiter ties the select lines.
- Ack in RUN:
  - Outstanding-1.
  - Push {bus_dat_i, issue PC} into the FIFO; the PC comes from an internal PC FIFO recorded at issue.
  - The cap guarantees the FIFO never overflows. The bench asserts no push when full.
- Pop:
  - When valid_o & pop_i, the head advances.
  - Ack and pop in the same cycle leaves the count unchanged.
  - pop_i with valid_o=0 is ignored.
- Latency: first word is valid 2 cycles after stb acceptance when the slave acks 1 cycle after acceptance (registered FIFO output).
- Redirect (pc_set_i=1, sampled on clock edge):
  - FIFO cleared; valid_o=0 next cycle.
  - Fetch address = {pc_i[31:2],2'b00}.
  - If outstanding (after this cycle's accept and ack) > 0: drain = outstanding, outstanding=0, go to DRAIN.
  - Otherwise stay in RUN; issue at the new address in the next cycle.
  - pc_set_i has priority over pop_i and over a push in the same cycle; that ack still counts toward the drain.
- DRAIN:
  - bus_stb_o=0, bus_cyc_o=1.
  - Each ack decrements drain; its data is discarded.
  - When drain reaches 0, return to RUN. The decrement to 0 occurs on the final ack's edge, so the first new stb appears the following cycle.
  - pc_set_i during DRAIN updates the fetch address only; the drain count continues.
- Ack while outstanding=0 and drain=0 is a protocol error: ignored, with no state change.
- Reset mid-transaction aborts immediately: cyc drops, and the slave is expected to be reset together.

Optional Feature:
- Macro PREFETCH_STATS_EN.
- When defined, add outputs stat_flush_o[15:0] and stat_discard_o[15:0].
  - stat_flush_o counts pc_set_i cycles.
  - stat_discard_o counts acks dropped in DRAIN.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. Reset release with RESET_PC=0, zero-wait slave (ack 1 cycle after accept, stall=0), pop_i=1 -> bus_adr_o issues 0,4,8,C...; valid_o streams word_pc_o=0,4,8... with no bubbles after the first word.
2. pop_i=0 with DEPTH=4 -> exactly 4 requests issued, bus_stb_o drops, FIFO holds PCs 0,4,8,C; then a single pop -> exactly one new request at 32'h10.
3. bus_stall_i=1 for 3 cycles mid-stream -> bus_adr_o held stable; no address skipped or duplicated in word_pc_o.
4. pc_set_i=1, pc_i=32'h1003 with 2 requests outstanding -> valid_o=0 next cycle, 2 acks discarded in DRAIN, next stb at 32'h1000, first delivered word_pc_o=32'h1000.
5. Start at RESET_PC=32'hFFFFFFF8 -> addresses FFFFFFF8, FFFFFFFC, 0, 4.
6. PREFETCH_STATS_EN defined, run scenario 4 twice -> stat_flush_o=2, stat_discard_o=4.

Source files
------------

// File: rtl/ifetch_prefetch_if.sv
// Fetch-side and Wishbone read-port bundle of the instruction prefetch queue.
// master = prefetch queue side, slave = fetch stage / bus slave side.
interface ifetch_prefetch_if;
  logic        pc_set_i;
  logic [31:0] pc_i;
  logic        pop_i;
  logic        valid_o;
  logic [31:0] word_o;
  logic [31:0] word_pc_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic [31:0] bus_adr_o;
  logic        bus_stall_i;
  logic        bus_ack_i;
  logic [31:0] bus_dat_i;

  modport master (
    input  pc_set_i, pc_i, pop_i, bus_stall_i, bus_ack_i, bus_dat_i,
    output valid_o, word_o, word_pc_o, bus_cyc_o, bus_stb_o, bus_adr_o
  );
  modport slave (
    output pc_set_i, pc_i, pop_i, bus_stall_i, bus_ack_i, bus_dat_i,
    input  valid_o, word_o, word_pc_o, bus_cyc_o, bus_stb_o, bus_adr_o
  );
endinterface

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch queue: sequential pipelined Wishbone reads into a small word/PC FIFO.
// Optional macro PREFETCH_STATS_EN adds saturating flush / discarded-ack counters.
module ifetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ifetch_prefetch_if.master bus
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]       stat_flush_o,
  output logic [15:0]       stat_discard_o
`endif
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t                 r_state;
  logic [31:0]            r_fadr;
  logic [CW-1:0]          r_cnt, r_out, r_drain;
  logic [AW-1:0]          r_rd, r_wr, r_prd, r_pwr;
  logic [DEPTH-1:0][31:0] r_dat, r_dpc, r_ipc;

  logic [CW:0]   w_used;
  logic          w_stb, w_acc, w_ack_run, w_ack_drn, w_push, w_pop;
  logic [CW-1:0] w_out_nxt, w_drain_nxt;

  // Buffered + in-flight never exceeds DEPTH, so an ack always has a free slot.
  assign w_used      = {1'b0, r_cnt} + {1'b0, r_out};
  assign w_stb       = rst_i && (r_state == ST_RUN) && (w_used < DEPTH[CW:0]);
  assign w_acc       = w_stb && !bus.bus_stall_i;
  assign w_ack_run   = bus.bus_ack_i && (r_state == ST_RUN) && (r_out != '0);
  assign w_ack_drn   = bus.bus_ack_i && (r_state == ST_DRAIN) && (r_drain != '0);
  assign w_push      = w_ack_run && !bus.pc_set_i;
  assign w_pop       = (r_cnt != '0) && bus.pop_i && !bus.pc_set_i;
  assign w_out_nxt   = r_out + CW'(w_acc) - CW'(w_ack_run);
  assign w_drain_nxt = r_drain - CW'(w_ack_drn);

  assign bus.bus_stb_o = w_stb;
  assign bus.bus_cyc_o = w_stb || (r_out != '0) || (r_state == ST_DRAIN);
  assign bus.bus_adr_o = r_fadr;
  assign bus.valid_o   = (r_cnt != '0);
  assign bus.word_o    = r_dat[r_rd];
  assign bus.word_pc_o = r_dpc[r_rd];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_RUN;
      r_fadr  <= RESET_PC;
      r_cnt   <= '0;
      r_out   <= '0;
      r_drain <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_prd   <= '0;
      r_pwr   <= '0;
      r_dat   <= '0;
      r_dpc   <= '0;
      r_ipc   <= '0;
    end else begin
      if (w_acc) begin
        r_ipc[r_pwr] <= r_fadr;
        r_pwr        <= r_pwr + 1'b1;
        r_fadr       <= r_fadr + 32'd4;
      end
      if (w_ack_run) r_prd <= r_prd + 1'b1;
      if (w_push) begin
        r_dat[r_wr] <= bus.bus_dat_i;
        r_dpc[r_wr] <= r_ipc[r_prd];
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt   <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_out   <= w_out_nxt;
      r_drain <= w_drain_nxt;
      if (r_state == ST_DRAIN && w_drain_nxt == '0) r_state <= ST_RUN;
      // Redirect wins over this cycle's accept/push/pop; in-flight reads become drain.
      if (bus.pc_set_i) begin
        r_fadr <= {bus.pc_i[31:2], 2'b00};
        r_rd   <= '0;
        r_wr   <= '0;
        r_cnt  <= '0;
        r_prd  <= '0;
        r_pwr  <= '0;
        if (r_state == ST_RUN) begin
          r_out <= '0;
          if (w_out_nxt != '0) begin
            r_drain <= w_out_nxt;
            r_state <= ST_DRAIN;
          end
        end
      end
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [15:0] r_sflush, r_sdisc;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sflush <= '0;
      r_sdisc  <= '0;
    end else begin
      if (bus.pc_set_i && r_sflush != 16'hFFFF) r_sflush <= r_sflush + 16'd1;
      if (w_ack_drn && r_sdisc != 16'hFFFF)     r_sdisc  <= r_sdisc + 16'd1;
    end
  end

  assign stat_flush_o   = r_sflush;
  assign stat_discard_o = r_sdisc;
`endif
endmodule
